// File: rtl/ex_div.sv
// ex_div: iterative RV32M divide unit for the EX stage.
// Radix-2 restoring division, one quotient bit per cycle, covering DIV/DIVU/REM/REMU.
// While an operation is in flight it requests a pipeline hold. On completion it presents
// the result and destination register for exactly one cycle.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   start_i        EX holds a divide op (sampled only in IDLE)
//   op_i           00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i     rs1 value
//   divisor_i      rs2 value
//   w_reg_addr_i   destination register of the divide op
//   flush_i        pipeline flush, aborts any operation
//   busy_o         registered, high in CALC and DONE
//   hold_req_o     combinational hold request to the pipeline controller
//   ready_o        registered one-cycle result strobe
//   result_o       registered quotient/remainder
//   w_reg_addr_o   destination register, valid with ready_o
module ex_div #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  input  logic [RW-1:0] w_reg_addr_i,
  input  logic          flush_i,
  output logic          busy_o,
  output logic          hold_req_o,
  output logic          ready_o,
  output logic [DW-1:0] result_o,
  output logic [RW-1:0] w_reg_addr_o
);

  localparam int unsigned CW = $clog2(DW) + 1;
  localparam logic [DW-1:0] MinNeg = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic          q_neg_q, q_neg_d;
  logic          r_neg_q, r_neg_d;
  logic [1:0]    op_q, op_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic [DW-1:0] result_q, result_d;
  logic [RW-1:0] waddr_q, waddr_d;

  logic          accept;
  logic          is_signed;
  logic          div_zero;
  logic          overflow;
  logic [DW-1:0] dvd_mag;
  logic [DW-1:0] dvs_mag;
  logic [DW:0]   rem_sh;
  logic [DW:0]   trial;
  logic [DW-1:0] rem_step;
  logic [DW-1:0] quo_step;

  assign accept    = (state_q == StIdle) && start_i && !flush_i;
  assign is_signed = !op_i[0];
  assign div_zero  = (divisor_i == '0);
  assign overflow  = is_signed && (dividend_i == MinNeg) && (divisor_i == '1);
  // The most negative value negates to itself, which is the correct unsigned magnitude.
  assign dvd_mag   = (is_signed && dividend_i[DW-1]) ? -dividend_i : dividend_i;
  assign dvs_mag   = (is_signed && divisor_i[DW-1]) ? -divisor_i : divisor_i;

  // rem stays below the divisor, so the shifted value minus the divisor fits DW+1 signed bits
  // and the top bit of trial is its sign.
  assign rem_sh   = {rem_q, quo_q[DW-1]};
  assign trial    = rem_sh - {1'b0, dvs_q};
  assign rem_step = trial[DW] ? rem_sh[DW-1:0] : trial[DW-1:0];
  assign quo_step = {quo_q[DW-2:0], !trial[DW]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d = (div_zero || overflow) ? StDone : StCalc;
          end
        end
        StCalc: begin
          if (cnt_q == CW'(1)) begin
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic
  always_comb begin
    hold_req_o = accept || (state_q == StCalc);
  end

  // Datapath next-state
  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    op_d     = op_q;
    rd_d     = rd_q;
    result_d = result_q;
    waddr_d  = waddr_q;

    if (accept) begin
      op_d    = op_i;
      rd_d    = w_reg_addr_i;
      q_neg_d = is_signed && (dividend_i[DW-1] ^ divisor_i[DW-1]);
      r_neg_d = is_signed && dividend_i[DW-1];
      dvs_d   = dvs_mag;
      quo_d   = dvd_mag;
      rem_d   = '0;
      cnt_d   = CW'(DW);
      if (div_zero) begin
        result_d = op_i[1] ? dividend_i : '1;
        waddr_d  = w_reg_addr_i;
      end else if (overflow) begin
        result_d = op_i[1] ? '0 : MinNeg;
        waddr_d  = w_reg_addr_i;
      end
    end else if ((state_q == StCalc) && !flush_i) begin
      cnt_d = cnt_q - CW'(1);
      rem_d = rem_step;
      quo_d = quo_step;
      if (cnt_q == CW'(1)) begin
        unique case (op_q)
          2'b00, 2'b01: result_d = q_neg_q ? -quo_step : quo_step;
          default:      result_d = r_neg_q ? -rem_step : rem_step;
        endcase
        waddr_d = rd_q;
      end
    end
  end

  assign busy_d  = (state_d != StIdle);
  assign ready_d = (state_d == StDone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      op_q     <= '0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
      waddr_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
    end
  end

  assign busy_o       = busy_q;
  assign ready_o      = ready_q;
  assign result_o     = result_q;
  assign w_reg_addr_o = waddr_q;

endmodule

// File: tb/tb_ex_div.sv
// Testbench for ex_div: directed vectors, scoreboard queue checked by an independent
// monitor on every ready_o strobe (result, destination register and arrival edge).
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  w_reg_addr_i;
  logic        flush_i;
  logic        busy_o;
  logic        hold_req_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  w_reg_addr_o;

  localparam logic [1:0] OpDiv = 2'b00, OpDivu = 2'b01, OpRem = 2'b10, OpRemu = 2'b11;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          edge_at;
  } exp_t;

  exp_t sb[$];
  int   edges  = 0;
  int   passed = 0;
  int   total  = 0;

  ex_div #(.DW(32), .RW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .op_i         (op_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .w_reg_addr_i (w_reg_addr_i),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .hold_req_o   (hold_req_o),
    .ready_o      (ready_o),
    .result_o     (result_o),
    .w_reg_addr_o (w_reg_addr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready_o) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_ready: got result 0x%08h with no pending op (t=%0t)",
                 result_o, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result_o, e.res);
        chk("rd", 32'(w_reg_addr_o), 32'(e.rd));
        chk("latency_edge", edges, e.edge_at);
      end
    end
  end

  // Called at a negedge; drives one start cycle and returns at the next negedge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input bit expect_res,
                       input logic [31:0] res);
    exp_t e;
    op_i         = op;
    dividend_i   = a;
    divisor_i    = b;
    w_reg_addr_i = rd;
    start_i      = 1'b1;
    if (expect_res) begin
      e.res     = res;
      e.rd      = rd;
      e.edge_at = edges + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hc;
    int e0;
    rst          = 1'b1;
    start_i      = 1'b0;
    flush_i      = 1'b0;
    op_i         = '0;
    dividend_i   = '0;
    divisor_i    = '0;
    w_reg_addr_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_rd", 32'(w_reg_addr_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // DIVU 100/7 with hold_req profile
    op_i = OpDivu; dividend_i = 32'd100; divisor_i = 32'd7; w_reg_addr_i = 5'd11;
    start_i = 1'b1;
    sb.push_back('{res: 32'd14, rd: 5'd11, edge_at: edges + 33});
    #1 chk("hold_cycle0", 32'(hold_req_o), 32'd1);
    hc = 0;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (k <= 32) hc += int'(hold_req_o);
      if (k == 33) begin
        chk("hold_in_done", 32'(hold_req_o), 32'd0);
        chk("busy_in_done", 32'(busy_o), 32'd1);
      end
    end
    chk("hold_count", 32'(hc), 32'd32);
    @(negedge clk);
    chk("ready_one_cycle", 32'(ready_o), 32'd0);

    issue(OpRemu, 32'd100, 32'd7, 5'd12, 33, 1'b1, 32'd2);          wait_idle();
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 5'd1, 33, 1'b1, 32'hFFFF_FFFD); wait_idle();
    issue(OpRem, 32'hFFFF_FFF9, 32'd2, 5'd2, 33, 1'b1, 32'hFFFF_FFFF); wait_idle();
    issue(OpDiv, 32'd7, 32'hFFFF_FFFE, 5'd3, 33, 1'b1, 32'hFFFF_FFFD); wait_idle();
    issue(OpRem, 32'd7, 32'hFFFF_FFFE, 5'd4, 33, 1'b1, 32'd1);         wait_idle();
    issue(OpDiv, 32'h8000_0000, 32'd2, 5'd5, 33, 1'b1, 32'hC000_0000); wait_idle();
    issue(OpDivu, 32'h8000_0000, 32'd2, 5'd6, 33, 1'b1, 32'h4000_0000); wait_idle();
    // Special cases, one-cycle latency
    issue(OpDivu, 32'd1234, 32'd0, 5'd7, 1, 1'b1, 32'hFFFF_FFFF);        wait_idle();
    issue(OpRemu, 32'd1234, 32'd0, 5'd8, 1, 1'b1, 32'd1234);             wait_idle();
    issue(OpDiv, 32'hFFFF_FFFB, 32'd0, 5'd9, 1, 1'b1, 32'hFFFF_FFFF);    wait_idle();
    issue(OpRem, 32'hFFFF_FFFB, 32'd0, 5'd10, 1, 1'b1, 32'hFFFF_FFFB);   wait_idle();
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1, 1'b1, 32'h8000_0000); wait_idle();
    issue(OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1, 1'b1, 32'd0);   wait_idle();

    // Flush at cycle 10, restart at cycle 12
    issue(OpDivu, 32'hFFFF_FFFF, 32'd3, 5'd15, 33, 1'b0, 32'd0);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy", 32'(busy_o), 32'd0);
    chk("flush_result_kept", result_o, 32'd0);
    @(negedge clk);
    issue(OpDivu, 32'd9, 32'd3, 5'd16, 33, 1'b1, 32'd3);
    wait_idle();

    // Flush together with start in IDLE: nothing starts
    op_i = OpDivu; dividend_i = 32'd50; divisor_i = 32'd5; start_i = 1'b1; flush_i = 1'b1;
    #1 chk("flush_start_hold", 32'(hold_req_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", 32'(busy_o), 32'd0);

    // Reset mid-operation at cycle 15
    issue(OpDivu, 32'd999, 32'd9, 5'd17, 33, 1'b0, 32'd0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_hold", 32'(hold_req_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(OpDivu, 32'd1000, 32'd10, 5'd18, 33, 1'b1, 32'd100);
    wait_idle();

    // start_i held high: one result every 34 cycles
    op_i = OpDivu; dividend_i = 32'd5; divisor_i = 32'd1; w_reg_addr_i = 5'd19;
    start_i = 1'b1;
    e0 = edges;
    for (int i = 0; i < 3; i++) sb.push_back('{res: 32'd5, rd: 5'd19, edge_at: e0 + 33 + 34 * i});
    repeat (101) @(negedge clk);
    start_i = 1'b0;
    wait_idle();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
